// File: rtl/cvp14_mem_responder_pkg.sv
// rtl/cvp14_mem_responder_pkg.sv - shared bus widths and burst FSM encodings for the CVP14 memory responder
package cvp14_mem_responder_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RBURST = 2'b01,
    WBURST = 2'b10
  } burstState_t;

endpackage

// File: rtl/cvp14_mem_responder_mem_rd_pipe.sv
// rtl/cvp14_mem_responder_mem_rd_pipe.sv - LAT-deep {valid,data} read pipe; data holds between reads
module mem_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         Clk1,
  input  logic         Reset,
  input  logic         inValid,
  input  logic [W-1:0] inData,
  output logic         outValid,
  output logic [W-1:0] outData
);

  logic [LAT-1:0] vPipe;
  logic [W-1:0]   dPipe [LAT];

  // Data stages load only behind a valid bit, so the last stage holds the previous word.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      vPipe          <= '0;
      dPipe[LAT-1]   <= '0;
    end else begin
      vPipe[0] <= inValid;
      if (inValid) dPipe[0] <= inData;
      for (int i = 1; i < LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
        if (vPipe[i-1]) dPipe[i] <= dPipe[i-1];
      end
    end
  end

  assign outValid = vPipe[LAT-1];
  assign outData  = dPipe[LAT-1];

endmodule

// File: rtl/cvp14_mem_responder.sv
// rtl/cvp14_mem_responder.sv - CVP14 system-memory responder: word array, read pipe, burst tracker, error flag
module cvp14_mem_responder
  import cvp14_mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 5
) (
  input  logic             Clk1,
  input  logic             Reset,
  input  logic [15:0]      Addr,
  input  logic             RD,
  input  logic             WR,
  input  logic [15:0]      WrData,
  input  logic             LdEn,
  input  logic [15:0]      LdAddr,
  input  logic [15:0]      LdData,
  output logic [15:0]      RdData,
  output logic             RdValid,
  output logic [CNT_W-1:0] BurstLen,
  output logic             BurstDone,
  output logic             Err
);

  logic [BUS_W-1:0] mem [2**ADDR_W];
  logic [BUS_W-1:0] readWord;
  logic             rdIssue;
  logic             ldOk;
  logic             unusedLdHigh;

  burstState_t      state;
  logic [CNT_W-1:0] count;
  logic [15:0]      prevAddr;
  logic             contig;
  logic             keep;

  assign rdIssue      = RD & ~WR;
  assign ldOk         = LdEn & ~RD & ~WR;
  assign unusedLdHigh = ^LdAddr[15:ADDR_W];

  // The array is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge Clk1) begin
    if (WR)        mem[Addr[ADDR_W-1:0]]   <= WrData;
    else if (ldOk) mem[LdAddr[ADDR_W-1:0]] <= LdData;
  end

  assign readWord = mem[Addr[ADDR_W-1:0]];

  mem_rd_pipe #(
    .LAT (READ_LAT),
    .W   (BUS_W)
  ) uRdPipe (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .inValid  (rdIssue),
    .inData   (readWord),
    .outValid (RdValid),
    .outData  (RdData)
  );

  always_comb begin
    contig = (Addr == prevAddr) || (Addr == prevAddr + 16'd1);
    keep   = contig && (((state == RBURST) && rdIssue) || ((state == WBURST) && WR));
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      prevAddr  <= '0;
      BurstLen  <= '0;
      BurstDone <= 1'b0;
      Err       <= 1'b0;
    end else begin
      BurstDone <= 1'b0;
      prevAddr  <= Addr;
      if ((RD && WR) || (LdEn && (RD || WR))) Err <= 1'b1;
      if (keep) begin
        if (count != '1) count <= count + 1'b1;
      end else begin
        // Any break (stop, direction swap or address jump) closes the open burst.
        if (state != IDLE) begin
          BurstLen  <= count;
          BurstDone <= 1'b1;
        end
        count <= 1;
        if (rdIssue)  state <= RBURST;
        else if (WR)  state <= WBURST;
        else          state <= IDLE;
      end
    end
  end

endmodule
